bus_arbiter_rr: RTL and testbench

Parametrised N-master bus arbiter, the successor to the fixed two-master arbiter inside the bus interconnect.
- Grants one master at a time using round-robin priority.
- Supports split transactions: a parked master is excluded from arbitration until its slave signals resume.
- Enforces a hold timeout so no master can own the bus indefinitely.
- Drives grant, arbiter_busy and bus_busy toward the masters, and the slave-select mux control toward the interconnect.

---
 rtl/bus_arbiter_rr_pkg.sv | 26 ++
 rtl/bus_arbiter_rr_rr_pick.sv | 31 +++
 rtl/bus_arbiter_rr.sv | 149 ++++++++++++++
 tb/tb_bus_arbiter_rr.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/bus_arbiter_rr_pkg.sv
// rtl/bus_arbiter_rr_pkg.sv - shared bus constants, arbiter state encoding and slave_sel slice helper
package bus_arbiter_rr_pkg;

    localparam int BUS_SLAVE_LEN = 2;
    localparam int MAX_MASTERS   = 8;
    localparam int MAX_SLAVE_LEN = 8;
    localparam int SEL_BITS      = MAX_MASTERS * MAX_SLAVE_LEN;

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_GRANT = 2'd1,
        ARB_OWNED = 2'd2
    } arb_state_t;

    // Extract master idx's field from a packed slave_sel bus zero-extended to SEL_BITS.
    function automatic logic [MAX_SLAVE_LEN-1:0] slave_sel_slice(
        input logic [SEL_BITS-1:0] sel,
        input int unsigned         idx,
        input int unsigned         len
    );
        logic [MAX_SLAVE_LEN-1:0] mask;
        mask = (MAX_SLAVE_LEN'(1) << len) - MAX_SLAVE_LEN'(1);
        return MAX_SLAVE_LEN'(sel >> (idx * len)) & mask;
    endfunction

endpackage

// File: rtl/bus_arbiter_rr_rr_pick.sv
// rtl/bus_arbiter_rr_rr_pick.sv - combinational rotating-priority picker
module rr_pick #(
    parameter int N  = 4,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  i_req,
    input  logic [IW-1:0] i_base,
    output logic [N-1:0]  o_onehot,
    output logic [IW-1:0] o_idx,
    output logic          o_valid
);

    logic [IW-1:0] w_cand;

    always_comb begin
        o_onehot = '0;
        o_idx    = '0;
        o_valid  = 1'b0;
        w_cand   = '0;
        // Walk from i_base upward with wrap; the first requester found wins.
        for (int k = 0; k < N; k++) begin
            w_cand = IW'((int'(i_base) + k) % N);
            if (!o_valid && i_req[w_cand]) begin
                o_valid          = 1'b1;
                o_onehot[w_cand] = 1'b1;
                o_idx            = w_cand;
            end
        end
    end

endmodule

// File: rtl/bus_arbiter_rr.sv
// rtl/bus_arbiter_rr.sv - N-master round-robin bus arbiter with split parking and hold timeout
module bus_arbiter_rr
    import bus_arbiter_rr_pkg::*;
#(
    parameter int NUM_MASTERS = 4,
    parameter int SLAVE_LEN   = BUS_SLAVE_LEN,
    parameter int TIMEOUT_LEN = 8,
    parameter int TIMEOUT_MAX = 200
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic [NUM_MASTERS-1:0]           request,
    input  logic [NUM_MASTERS*SLAVE_LEN-1:0] slave_sel,
    input  logic                             trans_done,
    input  logic                             split_req,
    input  logic [2**SLAVE_LEN-1:0]          split_resume,
    output logic [NUM_MASTERS-1:0]           grant,
    output logic [$clog2(NUM_MASTERS)-1:0]   grant_id,
    output logic [SLAVE_LEN-1:0]             grant_slave,
    output logic                             arbiter_busy,
    output logic                             bus_busy,
    output logic [NUM_MASTERS-1:0]           split_pending,
    output logic                             timeout
);

    localparam int IW = $clog2(NUM_MASTERS);

    arb_state_t               r_state, w_next_state;
    logic [NUM_MASTERS-1:0]   r_grant;
    logic [IW-1:0]            r_grant_id, r_last_owner, w_base;
    logic [SLAVE_LEN-1:0]     r_grant_slave;
    logic [SLAVE_LEN-1:0]     r_split_slave [NUM_MASTERS];
    logic [NUM_MASTERS-1:0]   r_split_pending, r_resume;
    logic [TIMEOUT_LEN-1:0]   r_count, w_count_inc;
    logic                     r_timeout;

    logic [NUM_MASTERS-1:0]   w_eligible, w_resumed;
    logic [NUM_MASTERS-1:0]   w_res_oh, w_elig_oh, w_pick_oh;
    logic [IW-1:0]            w_res_idx, w_elig_idx, w_pick_idx;
    logic                     w_res_valid, w_elig_valid;
    logic [SEL_BITS-1:0]      w_sel_ext;
    logic                     w_owned, w_done, w_park, w_expire, w_release, w_start;

    assign w_base     = (r_last_owner == IW'(NUM_MASTERS - 1)) ? '0 : r_last_owner + 1'b1;
    assign w_eligible = request & ~r_split_pending;
    assign w_resumed  = w_eligible & r_resume;

    rr_pick #(.N(NUM_MASTERS)) u_pick_resumed (
        .i_req    (w_resumed),
        .i_base   (w_base),
        .o_onehot (w_res_oh),
        .o_idx    (w_res_idx),
        .o_valid  (w_res_valid)
    );

    rr_pick #(.N(NUM_MASTERS)) u_pick_eligible (
        .i_req    (w_eligible),
        .i_base   (w_base),
        .o_onehot (w_elig_oh),
        .o_idx    (w_elig_idx),
        .o_valid  (w_elig_valid)
    );

    // Resumed masters are a subset of eligible ones, so eligible validity covers both.
    assign w_pick_oh  = w_res_valid ? w_res_oh  : w_elig_oh;
    assign w_pick_idx = w_res_valid ? w_res_idx : w_elig_idx;

    always_comb begin
        w_sel_ext = '0;
        w_sel_ext[NUM_MASTERS*SLAVE_LEN-1:0] = slave_sel;
    end

    assign w_owned     = (r_state == ARB_OWNED);
    assign w_done      = trans_done | ~request[r_grant_id];
    assign w_park      = split_req & ~w_done;
    assign w_count_inc = (r_count == '1) ? r_count : r_count + 1'b1;
    assign w_expire    = (TIMEOUT_MAX != 0) && (int'(w_count_inc) == TIMEOUT_MAX) && !w_done && !w_park;
    assign w_release   = w_owned & (w_done | w_park | w_expire);
    assign w_start     = (r_state == ARB_IDLE) & w_elig_valid;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= ARB_IDLE;
        else       r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ARB_IDLE:  if (w_elig_valid) w_next_state = ARB_GRANT;
            ARB_GRANT: w_next_state = ARB_OWNED;
            ARB_OWNED: if (w_done || w_park || w_expire) w_next_state = ARB_IDLE;
            default:   w_next_state = ARB_IDLE;
        endcase
    end

    always_comb begin
        arbiter_busy = (r_state == ARB_GRANT);
        bus_busy     = (r_state == ARB_OWNED);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_grant         <= '0;
            r_grant_id      <= '0;
            r_grant_slave   <= '0;
            r_last_owner    <= IW'(NUM_MASTERS - 1);
            r_count         <= '0;
            r_timeout       <= 1'b0;
            r_split_pending <= '0;
            r_resume        <= '0;
            for (int i = 0; i < NUM_MASTERS; i++) r_split_slave[i] <= '0;
        end else begin
            r_timeout <= w_owned & w_expire;
            if (r_state == ARB_GRANT) r_count <= '0;
            else if (w_owned)         r_count <= w_count_inc;

            for (int i = 0; i < NUM_MASTERS; i++) begin
                if (r_split_pending[i] && split_resume[r_split_slave[i]]) begin
                    r_split_pending[i] <= 1'b0;
                    r_resume[i]        <= 1'b1;
                end
            end

            if (w_start) begin
                r_grant       <= w_pick_oh;
                r_grant_id    <= w_pick_idx;
                r_grant_slave <= SLAVE_LEN'(slave_sel_slice(w_sel_ext, int'(w_pick_idx), SLAVE_LEN));
                r_last_owner  <= w_pick_idx;
            end else if (w_release) begin
                r_grant               <= '0;
                r_grant_id            <= '0;
                r_grant_slave         <= '0;
                r_resume[r_grant_id]  <= 1'b0;
                // Parking is written after the resume scan so a same-cycle resume cannot unpark it.
                if (w_park) begin
                    r_split_pending[r_grant_id] <= 1'b1;
                    r_split_slave[r_grant_id]   <= r_grant_slave;
                end
            end
        end
    end

    assign grant         = r_grant;
    assign grant_id      = r_grant_id;
    assign grant_slave   = r_grant_slave;
    assign split_pending = r_split_pending;
    assign timeout       = r_timeout;

endmodule

// File: tb/tb_bus_arbiter_rr.sv
// tb/tb_bus_arbiter_rr.sv - table-driven and sequence checks for bus_arbiter_rr
module tb_bus_arbiter_rr;

    logic       clk;
    logic       reset;
    logic [3:0] request;
    logic [7:0] slave_sel;
    logic       trans_done;
    logic       split_req;
    logic [3:0] split_resume;
    logic [3:0] grant;
    logic [1:0] grant_id;
    logic [1:0] grant_slave;
    logic       arbiter_busy;
    logic       bus_busy;
    logic [3:0] split_pending;
    logic       timeout;

    bus_arbiter_rr #(
        .NUM_MASTERS (4),
        .SLAVE_LEN   (2),
        .TIMEOUT_LEN (8),
        .TIMEOUT_MAX (5)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .request       (request),
        .slave_sel     (slave_sel),
        .trans_done    (trans_done),
        .split_req     (split_req),
        .split_resume  (split_resume),
        .grant         (grant),
        .grant_id      (grant_id),
        .grant_slave   (grant_slave),
        .arbiter_busy  (arbiter_busy),
        .bus_busy      (bus_busy),
        .split_pending (split_pending),
        .timeout       (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] req;
        logic [7:0] sel;
        logic       done;
        logic       split;
        logic [3:0] res;
        logic [3:0] eg;
        logic [1:0] eid;
        logic [1:0] egs;
        logic       eab;
        logic       ebb;
        logic [3:0] esp;
        logic       eto;
    } vec_t;

    vec_t vecs[$];
    int   checks   = 0;
    int   failures = 0;
    int   seq1 [5] = '{0, 1, 2, 3, 0};
    logic [3:0] oh;
    logic [1:0] id;

    task automatic add(input logic [3:0] req, input logic [7:0] sel, input logic done, input logic split,
                       input logic [3:0] res, input logic [3:0] eg, input logic [1:0] eid, input logic [1:0] egs,
                       input logic eab, input logic ebb, input logic [3:0] esp, input logic eto);
        vec_t v;
        v.req = req; v.sel = sel; v.done = done; v.split = split; v.res = res;
        v.eg = eg; v.eid = eid; v.egs = egs; v.eab = eab; v.ebb = ebb; v.esp = esp; v.eto = eto;
        vecs.push_back(v);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [3:0] eg, input logic [1:0] eid, input logic [1:0] egs,
                       input logic eab, input logic ebb, input logic [3:0] esp, input logic eto);
        logic [14:0] act, exp;
        act = {grant, grant_id, grant_slave, arbiter_busy, bus_busy, split_pending, timeout};
        exp = {eg, eid, egs, eab, ebb, esp, eto};
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%b required=%b (grant,id,slave,abusy,bbusy,split,tmo)", name, act, exp);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish in time");
        $fatal(1);
    end

    initial begin
        reset = 1'b1; request = '0; slave_sel = 8'hE4;
        trans_done = 1'b0; split_req = 1'b0; split_resume = '0;

        // Round robin over four requesters, two OWNED cycles each.
        for (int g = 0; g < 5; g++) begin
            oh = 4'b0001 << seq1[g];
            id = 2'(seq1[g]);
            add(4'hF, 8'hE4, 1'b0, 1'b0, 4'h0, oh, id, id, 1'b1, 1'b0, 4'h0, 1'b0);
            add(4'hF, 8'hE4, 1'b0, 1'b0, 4'h0, oh, id, id, 1'b0, 1'b1, 4'h0, 1'b0);
            add(4'hF, 8'hE4, 1'b0, 1'b0, 4'h0, oh, id, id, 1'b0, 1'b1, 4'h0, 1'b0);
            add(4'hF, 8'hE4, 1'b1, 1'b0, 4'h0, 4'h0, 2'd0, 2'd0, 1'b0, 1'b0, 4'h0, 1'b0);
        end
        // Split: master 2 (slave 1) parks, is skipped, then resumes ahead of 3 and 0.
        add(4'h4, 8'hD8, 1'b0, 1'b0, 4'h0, 4'b0100, 2'd2, 2'd1, 1'b1, 1'b0, 4'h0, 1'b0);
        add(4'h4, 8'hD8, 1'b0, 1'b0, 4'h0, 4'b0100, 2'd2, 2'd1, 1'b0, 1'b1, 4'h0, 1'b0);
        add(4'h4, 8'hD8, 1'b0, 1'b1, 4'h0, 4'b0000, 2'd0, 2'd0, 1'b0, 1'b0, 4'b0100, 1'b0);
        add(4'hF, 8'hD8, 1'b0, 1'b0, 4'h0, 4'b1000, 2'd3, 2'd3, 1'b1, 1'b0, 4'b0100, 1'b0);
        add(4'hF, 8'hD8, 1'b0, 1'b0, 4'h0, 4'b1000, 2'd3, 2'd3, 1'b0, 1'b1, 4'b0100, 1'b0);
        add(4'hF, 8'hD8, 1'b1, 1'b0, 4'h0, 4'b0000, 2'd0, 2'd0, 1'b0, 1'b0, 4'b0100, 1'b0);
        add(4'hF, 8'hD8, 1'b0, 1'b0, 4'h0, 4'b0001, 2'd0, 2'd0, 1'b1, 1'b0, 4'b0100, 1'b0);
        add(4'hF, 8'hD8, 1'b0, 1'b0, 4'h0, 4'b0001, 2'd0, 2'd0, 1'b0, 1'b1, 4'b0100, 1'b0);
        add(4'hF, 8'hD8, 1'b1, 1'b0, 4'h0, 4'b0000, 2'd0, 2'd0, 1'b0, 1'b0, 4'b0100, 1'b0);
        add(4'hF, 8'hD8, 1'b0, 1'b0, 4'h0, 4'b0010, 2'd1, 2'd2, 1'b1, 1'b0, 4'b0100, 1'b0);
        add(4'hF, 8'hD8, 1'b0, 1'b0, 4'h0, 4'b0010, 2'd1, 2'd2, 1'b0, 1'b1, 4'b0100, 1'b0);
        add(4'hF, 8'hD8, 1'b1, 1'b0, 4'h0, 4'b0000, 2'd0, 2'd0, 1'b0, 1'b0, 4'b0100, 1'b0);
        add(4'hF, 8'hD8, 1'b0, 1'b0, 4'h0, 4'b1000, 2'd3, 2'd3, 1'b1, 1'b0, 4'b0100, 1'b0);
        add(4'hF, 8'hD8, 1'b0, 1'b0, 4'h0, 4'b1000, 2'd3, 2'd3, 1'b0, 1'b1, 4'b0100, 1'b0);
        add(4'hF, 8'hD8, 1'b1, 1'b0, 4'b0010, 4'b0000, 2'd0, 2'd0, 1'b0, 1'b0, 4'b0000, 1'b0);
        add(4'hF, 8'hD8, 1'b0, 1'b0, 4'h0, 4'b0100, 2'd2, 2'd1, 1'b1, 1'b0, 4'h0, 1'b0);
        add(4'hF, 8'hD8, 1'b0, 1'b0, 4'h0, 4'b0100, 2'd2, 2'd1, 1'b0, 1'b1, 4'h0, 1'b0);
        add(4'hF, 8'hD8, 1'b1, 1'b0, 4'h0, 4'b0000, 2'd0, 2'd0, 1'b0, 1'b0, 4'h0, 1'b0);
        add(4'hF, 8'hD8, 1'b0, 1'b0, 4'h0, 4'b1000, 2'd3, 2'd3, 1'b1, 1'b0, 4'h0, 1'b0);
        add(4'hF, 8'hD8, 1'b0, 1'b0, 4'h0, 4'b1000, 2'd3, 2'd3, 1'b0, 1'b1, 4'h0, 1'b0);
        add(4'hF, 8'hD8, 1'b1, 1'b0, 4'h0, 4'b0000, 2'd0, 2'd0, 1'b0, 1'b0, 4'h0, 1'b0);
        // trans_done beats split_req; split_req and stray resume in IDLE do nothing.
        add(4'hF, 8'hD8, 1'b0, 1'b0, 4'h0, 4'b0001, 2'd0, 2'd0, 1'b1, 1'b0, 4'h0, 1'b0);
        add(4'hF, 8'hD8, 1'b0, 1'b0, 4'h0, 4'b0001, 2'd0, 2'd0, 1'b0, 1'b1, 4'h0, 1'b0);
        add(4'hF, 8'hD8, 1'b1, 1'b1, 4'h0, 4'b0000, 2'd0, 2'd0, 1'b0, 1'b0, 4'h0, 1'b0);
        add(4'h0, 8'hD8, 1'b0, 1'b1, 4'b1000, 4'b0000, 2'd0, 2'd0, 1'b0, 1'b0, 4'h0, 1'b0);

        repeat (3) tick();
        reset = 1'b0;
        chk("reset_state", 4'h0, 2'd0, 2'd0, 1'b0, 1'b0, 4'h0, 1'b0);

        foreach (vecs[i]) begin
            request = vecs[i].req; slave_sel = vecs[i].sel; trans_done = vecs[i].done;
            split_req = vecs[i].split; split_resume = vecs[i].res;
            tick();
            trans_done = 1'b0; split_req = 1'b0; split_resume = '0;
            chk($sformatf("vec%0d", i), vecs[i].eg, vecs[i].eid, vecs[i].egs, vecs[i].eab, vecs[i].ebb,
                vecs[i].esp, vecs[i].eto);
        end

        // Hold timeout: five OWNED cycles, then forced release without parking.
        request = 4'b0010;
        tick(); chk("tmo_grant", 4'b0010, 2'd1, 2'd2, 1'b1, 1'b0, 4'h0, 1'b0);
        for (int k = 0; k < 5; k++) begin
            tick(); chk($sformatf("tmo_owned%0d", k), 4'b0010, 2'd1, 2'd2, 1'b0, 1'b1, 4'h0, 1'b0);
        end
        request = 4'b1010;
        tick(); chk("tmo_fire", 4'h0, 2'd0, 2'd0, 1'b0, 1'b0, 4'h0, 1'b1);
        tick(); chk("tmo_next", 4'b1000, 2'd3, 2'd3, 1'b1, 1'b0, 4'h0, 1'b0);

        // Lone master 3: release at m, regrant at m+2.
        request = 4'b1000;
        tick(); chk("m3_owned", 4'b1000, 2'd3, 2'd3, 1'b0, 1'b1, 4'h0, 1'b0);
        trans_done = 1'b1;
        tick(); trans_done = 1'b0;
        chk("m3_release", 4'h0, 2'd0, 2'd0, 1'b0, 1'b0, 4'h0, 1'b0);
        tick(); chk("m3_regrant", 4'b1000, 2'd3, 2'd3, 1'b1, 1'b0, 4'h0, 1'b0);
        tick(); chk("m3_owned2", 4'b1000, 2'd3, 2'd3, 1'b0, 1'b1, 4'h0, 1'b0);
        request = 4'b0000;
        tick(); chk("req_drop_release", 4'h0, 2'd0, 2'd0, 1'b0, 1'b0, 4'h0, 1'b0);
        request = 4'b1000;
        tick(); chk("m3_grant_n1", 4'b1000, 2'd3, 2'd3, 1'b1, 1'b0, 4'h0, 1'b0);
        tick(); chk("m3_owned_n2", 4'b1000, 2'd3, 2'd3, 1'b0, 1'b1, 4'h0, 1'b0);
        split_req = 1'b1;
        tick(); split_req = 1'b0;
        chk("m3_park", 4'h0, 2'd0, 2'd0, 1'b0, 1'b0, 4'b1000, 1'b0);
        tick(); chk("m3_parked_ignored", 4'h0, 2'd0, 2'd0, 1'b0, 1'b0, 4'b1000, 1'b0);

        // Asynchronous reset in the middle of an OWNED cycle.
        request = 4'b0001;
        tick(); chk("m0_grant", 4'b0001, 2'd0, 2'd0, 1'b1, 1'b0, 4'b1000, 1'b0);
        tick(); chk("m0_owned", 4'b0001, 2'd0, 2'd0, 1'b0, 1'b1, 4'b1000, 1'b0);
        #3 reset = 1'b1;
        #1 chk("async_reset", 4'h0, 2'd0, 2'd0, 1'b0, 1'b0, 4'h0, 1'b0);
        request = 4'hF;
        #2 reset = 1'b0;
        tick(); chk("post_reset_grant", 4'b0001, 2'd0, 2'd0, 1'b1, 1'b0, 4'h0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
